// File: rtl/prim_dispatch.sv
// prim_dispatch: draw-command FIFO and scheduler that owns the framebuffer write port.
// Optional feature: define ADDR_CLIP_EN to suppress writes whose address is >= NPIX.

module prim_dispatch #(
  parameter int DEPTH = 4,
  parameter int NPIX  = 307200,
  parameter int AW    = 19,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [37:0]   cmd_positions,
  input  logic [CW-1:0] cmd_color,
  output logic [37:0]   line_positions,
  output logic          line_select,
  input  logic [AW-1:0] line_address,
  input  logic          line_done,
  output logic [37:0]   circ_positions,
  output logic          circ_select,
  input  logic [AW-1:0] circ_address,
  input  logic          circ_done,
  output logic          fb_wr_en,
  output logic [AW-1:0] fb_address,
  output logic [CW-1:0] fb_color,
  output logic          busy,
  output logic          err_op
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);

  typedef enum logic [1:0] {
    OP_LINE  = 2'b00,
    OP_CIRC  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN_LINE,
    RUN_CIRC,
    RUN_CLR,
    GAP
  } state_t;

  typedef struct packed {
    logic [1:0]    op;
    logic [37:0]   pos;
    logic [CW-1:0] color;
  } cmd_t;

  cmd_t            mem [DEPTH];
  cmd_t            hold;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CNTW-1:0] count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  state_t          state;
  state_t          next_state;
  logic            run_started;
  logic [AW-1:0]   clr_cnt;
  logic            raw_wr;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  assign full      = (count == CNTW'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign pop       = (state == IDLE) && !empty;

  // NOTE: the storage array has no reset; validity is tracked by count alone,
  // so clearing the payload would only cost flops and reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: cmd_op, pos: cmd_positions, color: cmd_color};
  end

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Holding registers keep the popped command stable for the engine from LOAD on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (pop) begin
      hold <= mem[rd_ptr];
    end
  end

  // ---------------------------------------------------------------------------
  // Run bookkeeping: engine load-cycle flag and clear sweep counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_started <= 1'b0;
    end else begin
      run_started <= (state == RUN_LINE) || (state == RUN_CIRC);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (state == RUN_CLR) begin
      clr_cnt <= (clr_cnt == LAST_PIX) ? '0 : clr_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (!empty) next_state = LOAD;
      LOAD: begin
        case (op_t'(hold.op))
          OP_LINE:  next_state = RUN_LINE;
          OP_CIRC:  next_state = RUN_CIRC;
          OP_CLEAR: next_state = RUN_CLR;
          default:  next_state = GAP;
        endcase
      end
      RUN_LINE: if (line_done) next_state = GAP;
      RUN_CIRC: if (circ_done) next_state = GAP;
      RUN_CLR:  if (clr_cnt == LAST_PIX) next_state = GAP;
      GAP:      next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    line_select = 1'b0;
    circ_select = 1'b0;
    raw_wr      = 1'b0;
    fb_address  = '0;
    fb_color    = '0;
    err_op      = 1'b0;
    case (state)
      LOAD:     err_op = (op_t'(hold.op) == OP_RSVD);
      RUN_LINE: begin
        line_select = 1'b1;
        raw_wr      = run_started;
        fb_address  = line_address;
        fb_color    = hold.color;
      end
      RUN_CIRC: begin
        circ_select = 1'b1;
        raw_wr      = run_started;
        fb_address  = circ_address;
        fb_color    = hold.color;
      end
      RUN_CLR: begin
        raw_wr      = 1'b1;
        fb_address  = clr_cnt;
        fb_color    = hold.color;
      end
      default: ;
    endcase
  end

`ifdef ADDR_CLIP_EN
  // Out-of-range engine addresses are dropped; the engine itself still runs to done.
  localparam logic [AW:0] NPIX_EXT = (AW + 1)'(NPIX);
  assign fb_wr_en = raw_wr && ({1'b0, fb_address} < NPIX_EXT);
`else
  assign fb_wr_en = raw_wr;
`endif

  assign line_positions = hold.pos;
  assign circ_positions = hold.pos;
  assign busy           = (state != IDLE) || !empty;

endmodule

// File: tb/tb_prim_dispatch.sv
// Self-checking bench for prim_dispatch: behavioural engine models plus an ordered
// expected-event queue built from each accepted command.

module tb_prim_dispatch;

  localparam int DEPTH = 4;
  localparam int NPIX  = 256;
  localparam int AW    = 19;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [37:0]   cmd_positions;
  logic [CW-1:0] cmd_color;
  logic [37:0]   line_positions;
  logic          line_select;
  logic [AW-1:0] line_address;
  logic          line_done;
  logic [37:0]   circ_positions;
  logic          circ_select;
  logic [AW-1:0] circ_address;
  logic          circ_done;
  logic          fb_wr_en;
  logic [AW-1:0] fb_address;
  logic [CW-1:0] fb_color;
  logic          busy;
  logic          err_op;

  prim_dispatch #(.DEPTH(DEPTH), .NPIX(NPIX), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_positions(cmd_positions), .cmd_color(cmd_color),
    .line_positions(line_positions), .line_select(line_select),
    .line_address(line_address), .line_done(line_done),
    .circ_positions(circ_positions), .circ_select(circ_select),
    .circ_address(circ_address), .circ_done(circ_done),
    .fb_wr_en(fb_wr_en), .fb_address(fb_address), .fb_color(fb_color),
    .busy(busy), .err_op(err_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    logic [AW-1:0] addr;
    logic [CW-1:0] color;
    bit            first;
  } item_t;

  typedef struct {
    bit          is_circ;
    logic [37:0] pos;
  } sel_t;

  item_t exp_q[$];
  sel_t  sel_q[$];
  int    line_len_q[$];
  int    circ_len_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the write/err sequence one accepted command must produce.
  task automatic add_cmd(input logic [1:0] op, input logic [37:0] pos,
                         input logic [CW-1:0] color, input int len);
    bit first = 1'b1;
    int a;
    bit keep;
    case (op)
      2'd0, 2'd1: begin
        sel_q.push_back('{is_circ: (op == 2'd1), pos: pos});
        if (op == 2'd1) circ_len_q.push_back(len);
        else            line_len_q.push_back(len);
        for (int k = 1; k <= len; k++) begin
          a = int'(pos[7:0]) + k;
`ifdef ADDR_CLIP_EN
          keep = (a < NPIX);
`else
          keep = 1'b1;
`endif
          if (keep) begin
            exp_q.push_back('{is_err: 1'b0, addr: AW'(a), color: color, first: first});
            first = 1'b0;
          end
        end
      end
      2'd2: begin
        for (int p = 0; p < NPIX; p++) begin
          exp_q.push_back('{is_err: 1'b0, addr: AW'(p), color: color, first: (p == 0)});
        end
      end
      default: exp_q.push_back('{is_err: 1'b1, addr: '0, color: '0, first: 1'b0});
    endcase
  endtask

  task automatic push(input logic [1:0] op, input logic [37:0] pos,
                      input logic [CW-1:0] color, input int len);
    int waited = 0;
    cmd_valid     = 1'b1;
    cmd_op        = op;
    cmd_positions = pos;
    cmd_color     = color;
    while (!cmd_ready && waited < 5000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 5000) check("push_ready_timeout", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    add_cmd(op, pos, color, len);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic wait_sel(input bit circ);
    int n = 0;
    while (!(circ ? circ_select : line_select) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("wait_select", circ ? circ_select : line_select, 1);
  endtask

  // Engine models: address = base byte of positions + cycles since select rose,
  // done after the popped length; stray done pulses while not selected.
  initial begin
    int  lk = 0, ck = 0, llen = 1, clen = 1;
    bit  lprev = 1'b0, cprev = 1'b0;
    line_address = '0; line_done = 1'b0;
    circ_address = '0; circ_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (line_select && !lprev) begin
        lk = 0;
        if (line_len_q.size() > 0) llen = line_len_q.pop_front();
        else begin llen = 1; check("line_len_avail", line_len_q.size(), 1); end
      end else if (line_select) lk++;
      lprev        = line_select;
      line_address = AW'(line_positions[7:0]) + AW'(lk);
      line_done    = line_select ? (lk == llen) : ($urandom_range(0, 7) == 0);

      if (circ_select && !cprev) begin
        ck = 0;
        if (circ_len_q.size() > 0) clen = circ_len_q.pop_front();
        else begin clen = 1; check("circ_len_avail", circ_len_q.size(), 1); end
      end else if (circ_select) ck++;
      cprev        = circ_select;
      circ_address = AW'(circ_positions[7:0]) + AW'(ck);
      circ_done    = circ_select ? (ck == clen) : ($urandom_range(0, 7) == 0);
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    int    quiet = 0;
    bit    have_w = 1'b0, lp = 1'b0, cp = 1'b0;
    sel_t  cur_l = '{is_circ: 1'b0, pos: '0};
    sel_t  cur_c = '{is_circ: 1'b1, pos: '0};
    item_t it;
    forever begin
      @(negedge clk);
      if (rst) begin
        quiet = 0; have_w = 1'b0; lp = 1'b0; cp = 1'b0;
      end else begin
        if (line_select || circ_select) check("sel_exclusive", line_select & circ_select, 0);
        if (line_select && !lp) begin
          if (sel_q.size() > 0) begin
            cur_l = sel_q.pop_front();
            check("sel_kind_line", cur_l.is_circ, 0);
          end else check("sel_unexpected_line", line_select, 0);
        end
        if (circ_select && !cp) begin
          if (sel_q.size() > 0) begin
            cur_c = sel_q.pop_front();
            check("sel_kind_circ", cur_c.is_circ, 1);
          end else check("sel_unexpected_circ", circ_select, 0);
        end
        if (line_select) check("line_positions", line_positions, cur_l.pos);
        if (circ_select) check("circ_positions", circ_positions, cur_c.pos);
        lp = line_select;
        cp = circ_select;

        if (err_op) begin
          if (exp_q.size() == 0) check("err_unexpected", err_op, 0);
          else begin
            it = exp_q.pop_front();
            check("err_order", it.is_err, 1);
          end
        end
        if (fb_wr_en) begin
          if (exp_q.size() == 0) check("write_unexpected", fb_wr_en, 0);
          else begin
            it = exp_q.pop_front();
            check("write_kind", it.is_err, 0);
            check("fb_address", fb_address, it.addr);
            check("fb_color", fb_color, it.color);
            if (it.first && have_w) check("gap_ge3", quiet >= 3, 1);
          end
          have_w = 1'b1;
          quiet  = 0;
        end else begin
          quiet++;
        end
      end
    end
  end

  initial begin
    logic [37:0] pos;
    logic [1:0]  op;
    int          r;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_positions = '0; cmd_color = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_fb_wr_en", fb_wr_en, 0);
    check("rst_selects", {line_select, circ_select}, 0);
    check("rst_err_op", err_op, 0);
    check("rst_positions", line_positions, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);

    // Circle of 20 writes in colour FF, select latency from an idle, empty FIFO.
    push(2'b01, 38'b01010000000111100000001111110000000000, 8'hFF, 20);
    @(negedge clk); check("lat_cycle0", circ_select, 0);
    @(negedge clk); check("lat_cycle1", circ_select, 0);
    check("lat_busy", busy, 1);
    @(negedge clk); check("lat_cycle2", circ_select, 1);
    wait_idle("circle");

    // Fill the FIFO while a long line runs.
    push(2'b00, {30'h2abc_1234, 8'd10}, 8'h11, 30);
    wait_sel(1'b0);
    push(2'b00, {30'h0000_0f0f, 8'd40}, 8'h22, 5);
    push(2'b01, {30'h1234_5678, 8'd90}, 8'h33, 7);
    push(2'b00, {30'h3fff_ffff, 8'd150}, 8'h44, 3);
    push(2'b10, 38'h0, 8'h55, 0);
    check("full_cmd_ready", cmd_ready, 0);
    check("full_busy", busy, 1);
    wait_idle("fill");

    // Two clears back to back: the second must restart at address 0.
    push(2'b10, 38'h0, 8'h66, 0);
    push(2'b10, 38'h0, 8'h99, 0);
    wait_idle("clear");

    // Reserved opcode followed by a line.
    push(2'b11, 38'h15_5555_5555, 8'h5A, 0);
    push(2'b00, {30'h0101_0101, 8'd77}, 8'h3C, 6);
    wait_idle("reserved");

    // Engine addresses crossing the end of the framebuffer.
    push(2'b00, {30'h0, 8'd250}, 8'h77, 10);
    wait_idle("clip");

    // Randomised command stream.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      pos = {6'($urandom), 32'($urandom)};
      pos[7:0] = 8'($urandom_range(0, NPIX - 40));
      push(op, pos, 8'($urandom), $urandom_range(1, 24));
    end
    wait_idle("random");

    // Reset in the middle of a circle with two commands queued.
    push(2'b01, {30'h0abc_0def, 8'd20}, 8'hC3, 30);
    wait_sel(1'b1);
    repeat (5) @(posedge clk);
    #1;
    push(2'b00, {30'h0, 8'd60}, 8'h01, 4);
    push(2'b10, 38'h0, 8'h02, 0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_circ_select", circ_select, 0);
    check("midrst_line_select", line_select, 0);
    check("midrst_fb_wr_en", fb_wr_en, 0);
    check("midrst_busy", busy, 0);
    exp_q.delete(); sel_q.delete(); line_len_q.delete(); circ_len_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_cmd_ready", cmd_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
